// File: rtl/estados_pkg.sv
// Screen-state encoding shared by the flow controller, the renderer and the game logic.
package estados_pkg;

   typedef logic [1:0] estado_t;

   localparam estado_t EST_INICIAL = 2'd0;
   localparam estado_t EST_JOGO    = 2'd1;
   localparam estado_t EST_VITORIA = 2'd2;
   localparam estado_t EST_DERROTA = 2'd3;

   // Counter width for a 0..n-1 range, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/controle_estados_if.sv
// Game-side signals of the flow controller: the button, frame and game events in, and the screen selection out.
interface controle_estados_if;
   import estados_pkg::*;

   logic    botao_start;
   logic    frame_tick;
   logic    evento_vitoria;
   logic    evento_derrota;
   estado_t estado;
   logic    troca;
   logic    reset_jogo;
   logic    start_pulse;

   modport master (
      output botao_start, frame_tick, evento_vitoria, evento_derrota,
      input  estado, troca, reset_jogo, start_pulse
   );

   modport slave (
      input  botao_start, frame_tick, evento_vitoria, evento_derrota,
      output estado, troca, reset_jogo, start_pulse
   );

endinterface

// File: rtl/debounce_botao.sv
// Start-button conditioner: 2-flop synchronizer, stability counter and a single-cycle press pulse.
// A press only counts once the button has been seen released after reset.
module debounce_botao
   import estados_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic entrada,
   output logic pulso
);

   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          vld1_q, vld2_q;
   logic          filt_q, filt_d, filt_dly_q;
   logic          arm_q, arm_d;
   logic          pulso_q, pulso_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Filter update, release arming and press-edge detection.
   always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (sync2_q == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d  = '0;
         filt_d = sync2_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      // vld2_q marks the synchronizer as holding a real sample rather than its reset value.
      arm_d   = arm_q | (vld2_q & ~sync2_q);
      pulso_d = filt_q & ~filt_dly_q & arm_q;
   end

   // Synchronizer, debounce state and pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         vld1_q     <= 1'b0;
         vld2_q     <= 1'b0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         arm_q      <= 1'b0;
         pulso_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= entrada;
         sync2_q    <= sync1_q;
         vld1_q     <= 1'b1;
         vld2_q     <= vld1_q;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         arm_q      <= arm_d;
         pulso_q    <= pulso_d;
         cnt_q      <= cnt_d;
      end
   end

   assign pulso = pulso_q;

endmodule

// File: rtl/controle_estados.sv
// Game-flow controller: picks the screen shown by the renderer, blinks the title screen,
// and leaves the end screens on timeout or on a new start press.
module controle_estados
   import estados_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int BLINK_FRAMES      = 30,
   parameter int END_SCREEN_FRAMES = 300
) (
   input logic               clk,
   input logic               reset,
   controle_estados_if.slave bus
);

   localparam int            BW        = cnt_width(BLINK_FRAMES);
   localparam int            EW        = cnt_width(END_SCREEN_FRAMES);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
   localparam logic [EW-1:0] END_MAX   = EW'(END_SCREEN_FRAMES - 1);

   estado_t       estado_q, estado_d;
   logic [BW-1:0] blink_q, blink_d;
   logic [EW-1:0] fim_q, fim_d;
   logic          troca_q, troca_d;
   logic          reset_jogo_q, reset_jogo_d;
   logic          start_pulse_s;

   debounce_botao #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .entrada(bus.botao_start),
      .pulso  (start_pulse_s)
   );

   // State, counter and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q     <= EST_INICIAL;
         blink_q      <= '0;
         fim_q        <= '0;
         troca_q      <= 1'b0;
         reset_jogo_q <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         blink_q      <= blink_d;
         fim_q        <= fim_d;
         troca_q      <= troca_d;
         reset_jogo_q <= reset_jogo_d;
      end
   end

   // Next screen; a simultaneous defeat and victory resolves to defeat.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         EST_INICIAL: begin
            if (start_pulse_s) estado_d = EST_JOGO;
            else               estado_d = EST_INICIAL;
         end
         EST_JOGO: begin
            if (bus.evento_derrota)      estado_d = EST_DERROTA;
            else if (bus.evento_vitoria) estado_d = EST_VITORIA;
            else                         estado_d = EST_JOGO;
         end
         EST_VITORIA, EST_DERROTA: begin
            if (start_pulse_s || (bus.frame_tick && (fim_q == END_MAX))) estado_d = EST_INICIAL;
            else                                                          estado_d = estado_q;
         end
         default: estado_d = EST_INICIAL;
      endcase
   end

   // Blink and end-screen counters plus the registered outputs.
   always_comb begin
      blink_d      = blink_q;
      fim_d        = fim_q;
      troca_d      = troca_q;
      reset_jogo_d = 1'b0;
      case (estado_q)
         EST_INICIAL: begin
            fim_d = '0;
            if (start_pulse_s) begin
               blink_d      = '0;
               troca_d      = 1'b0;
               reset_jogo_d = 1'b1;
            end else if (bus.frame_tick) begin
               if (blink_q == BLINK_MAX) begin
                  blink_d = '0;
                  troca_d = ~troca_q;
               end else begin
                  blink_d = blink_q + BW'(1);
               end
            end else begin
               blink_d = blink_q;
            end
         end
         EST_JOGO: begin
            blink_d = '0;
            fim_d   = '0;
            troca_d = 1'b0;
         end
         EST_VITORIA, EST_DERROTA: begin
            blink_d = '0;
            troca_d = 1'b0;
            if (estado_d == EST_INICIAL) fim_d = '0;
            else if (bus.frame_tick)     fim_d = fim_q + EW'(1);
            else                         fim_d = fim_q;
         end
         default: begin
            blink_d = '0;
            fim_d   = '0;
            troca_d = 1'b0;
         end
      endcase
   end

   assign bus.estado      = estado_q;
   assign bus.troca       = troca_q;
   assign bus.reset_jogo  = reset_jogo_q;
   assign bus.start_pulse = start_pulse_s;

endmodule

// File: tb/tb_controle_estados.sv
// Directed bench for controle_estados with short debounce, blink and end-screen periods.
module tb_controle_estados;
   import estados_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   controle_estados_if bus_if ();

   controle_estados #(
      .DEBOUNCE_CYCLES  (4),
      .BLINK_FRAMES     (2),
      .END_SCREEN_FRAMES(3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_pulse();
      bus_if.frame_tick = 1'b1;
      tick();
      bus_if.frame_tick = 1'b0;
   endtask

   // Returns in the cycle where start_pulse is visible; expected latency is 2 + 4 + 1.
   task automatic press_button(input string tag);
      int lat;
      lat = 0;
      bus_if.botao_start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus_if.start_pulse === 1'b1) begin
            lat = i;
            break;
         end
      end
      check_val(tag, lat, 7);
   endtask

   task automatic release_button(input string tag);
      int n;
      n = 0;
      bus_if.botao_start = 1'b0;
      repeat (10) begin
         tick();
         if (bus_if.start_pulse === 1'b1) n++;
      end
      check_val(tag, n, 0);
   endtask

   task automatic enter_vitoria();
      press_button("lat_to_jogo");
      tick();
      check_val("est_jogo", bus_if.estado, EST_JOGO);
      release_button("rel_in_jogo");
      bus_if.evento_vitoria = 1'b1;
      tick();
      bus_if.evento_vitoria = 1'b0;
      check_val("est_vitoria", bus_if.estado, EST_VITORIA);
   endtask

   initial begin
      bus_if.botao_start    = 1'b0;
      bus_if.frame_tick     = 1'b0;
      bus_if.evento_vitoria = 1'b0;
      bus_if.evento_derrota = 1'b0;

      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      check_val("rst_estado", bus_if.estado, EST_INICIAL);
      check_val("rst_troca", bus_if.troca, 0);
      check_val("rst_reset_jogo", bus_if.reset_jogo, 0);
      check_val("rst_start_pulse", bus_if.start_pulse, 0);
      tick();

      // Title-screen blink: toggles after frame ticks 2 and 4.
      for (int k = 1; k <= 5; k++) begin
         frame_pulse();
         check_val("blink_troca", bus_if.troca, ((k == 2) || (k == 3)) ? 1 : 0);
         check_val("blink_estado", bus_if.estado, EST_INICIAL);
      end

      // Bouncy press then a steady hold.
      for (int b = 0; b < 4; b++) begin
         bus_if.botao_start = ((b % 2) == 0) ? 1'b1 : 1'b0;
         tick();
         check_val("bounce_no_pulse", bus_if.start_pulse, 0);
      end
      bus_if.botao_start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check_val("hold_start_pulse", bus_if.start_pulse, (i == 7) ? 1 : 0);
         check_val("hold_reset_jogo", bus_if.reset_jogo, (i == 8) ? 1 : 0);
         check_val("hold_estado", bus_if.estado, (i >= 8) ? EST_JOGO : EST_INICIAL);
         if (i >= 8) check_val("jogo_troca", bus_if.troca, 0);
      end
      release_button("rel_no_pulse");
      check_val("jogo_kept", bus_if.estado, EST_JOGO);

      // Simultaneous events: defeat has priority; later events are ignored.
      bus_if.evento_vitoria = 1'b1;
      bus_if.evento_derrota = 1'b1;
      tick();
      bus_if.evento_vitoria = 1'b0;
      bus_if.evento_derrota = 1'b0;
      check_val("both_events", bus_if.estado, EST_DERROTA);
      bus_if.evento_vitoria = 1'b1;
      tick();
      bus_if.evento_vitoria = 1'b0;
      check_val("vit_in_derrota", bus_if.estado, EST_DERROTA);

      // Leave the defeat screen with the button.
      press_button("lat_exit_der");
      check_val("der_before_edge", bus_if.estado, EST_DERROTA);
      tick();
      check_val("der_exit_start", bus_if.estado, EST_INICIAL);
      release_button("rel_after_der");

      // Victory timeout after three frame ticks.
      enter_vitoria();
      frame_pulse();
      check_val("vit_tick1", bus_if.estado, EST_VITORIA);
      check_val("vit_troca", bus_if.troca, 0);
      tick();
      frame_pulse();
      check_val("vit_tick2", bus_if.estado, EST_VITORIA);
      tick();
      frame_pulse();
      check_val("vit_timeout", bus_if.estado, EST_INICIAL);
      tick();

      // Start press coinciding with the first frame tick.
      enter_vitoria();
      press_button("lat_vit_tick1");
      bus_if.frame_tick = 1'b1;
      tick();
      bus_if.frame_tick = 1'b0;
      check_val("vit_start_tick1", bus_if.estado, EST_INICIAL);
      tick();
      check_val("vit_single_trans", bus_if.estado, EST_INICIAL);
      release_button("rel_after_vit1");

      // Start press coinciding with the timeout tick: still a single transition.
      enter_vitoria();
      frame_pulse();
      tick();
      frame_pulse();
      tick();
      press_button("lat_vit_tick3");
      bus_if.frame_tick = 1'b1;
      tick();
      bus_if.frame_tick = 1'b0;
      check_val("vit_start_timeout", bus_if.estado, EST_INICIAL);
      tick();
      check_val("vit_timeout_single", bus_if.estado, EST_INICIAL);
      check_val("no_reset_jogo", bus_if.reset_jogo, 0);
      release_button("rel_after_vit3");

      // Asynchronous reset mid-game with the button held across its release.
      press_button("lat_pre_reset");
      tick();
      check_val("pre_reset_jogo", bus_if.estado, EST_JOGO);
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      check_val("async_rst_estado", bus_if.estado, EST_INICIAL);
      check_val("async_rst_troca", bus_if.troca, 0);
      check_val("async_rst_pulse", bus_if.start_pulse, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      begin
         int n;
         n = 0;
         repeat (20) begin
            tick();
            if (bus_if.start_pulse === 1'b1) n++;
         end
         check_val("held_through_reset", n, 0);
      end
      check_val("held_estado", bus_if.estado, EST_INICIAL);
      release_button("rel_after_reset");
      press_button("lat_after_reset");
      tick();
      check_val("repress_estado", bus_if.estado, EST_JOGO);
      check_val("repress_reset_jogo", bus_if.reset_jogo, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/controle_estados.md
Name: controle_estados

Overview:
- Game-flow controller that sits directly upstream of the screen renderer.
- Produces the 2-bit `estado` that selects the initial, game, victory or defeat screen.
- Produces the `troca` blink toggle used by the initial screen.
- Debounces the start button, sequences the game states from game-logic events, and auto-returns from the end screens after a timeout.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clk cycles the synchronized button level must hold stable before it is accepted (20 ms at 50 MHz).
- BLINK_FRAMES, 30, frame_tick pulses between `troca` toggles in INICIAL.
- END_SCREEN_FRAMES, 300, frame_tick pulses spent in VITORIA/DERROTA before returning to INICIAL.

Ports:
- clk  in  1  system/pixel clock; the block's only clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- botao_start  in  1  raw, asynchronous, bouncy start button (1 = pressed).
- frame_tick  in  1  one-cycle pulse per video frame (from the VGA sync counter at end of frame).
- evento_vitoria  in  1  one-cycle pulse from game logic: player won.
- evento_derrota  in  1  one-cycle pulse from game logic: player lost.
- estado  out  2  0=INICIAL, 1=JOGO, 2=VITORIA, 3=DERROTA; registered.
- troca  out  1  blink phase for the initial screen; registered.
- reset_jogo  out  1  one-cycle pulse that clears game logic on entry to JOGO.
- start_pulse  out  1  debounced single-cycle press pulse, exported for the bench/other consumers.

Behaviour:
- Reset (reset=0, async) drives:
  - estado=0, troca=0, reset_jogo=0, start_pulse=0.
  - All counters and the synchronizer/debounce flops to 0.
- Button path:
  - 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized level differs from the filtered level and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the filtered level takes the synchronized level and the counter clears.
  - start_pulse=1 for exactly one cycle on a 0->1 edge of the filtered level.
  - No pulse on release. Holding the button produces exactly one pulse.
- FSM, registered, one transition per cycle:
  - INICIAL:
    - Blink counter increments on each frame_tick. At BLINK_FRAMES-1 it wraps to 0 and `troca` inverts.
    - On start_pulse: next state JOGO, reset_jogo=1 in that same next cycle only, troca=0, blink counter=0.
  - JOGO:
    - evento_derrota -> DERROTA; evento_vitoria -> VITORIA.
    - If both are asserted in the same cycle, DERROTA wins.
    - start_pulse is ignored.
    - troca is held at 0.
  - VITORIA / DERROTA:
    - The end counter is cleared on entry and increments on each frame_tick.
    - When it reaches END_SCREEN_FRAMES-1 with a frame_tick, or on start_pulse, next state is INICIAL.
    - If both occur in the same cycle, exactly one transition happens.
    - Game events are ignored. troca=0.
- Events in any state other than JOGO are ignored; they are not latched.
- Latency:
  - Event to estado change: 1 cycle.
  - Button press to start_pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Counter widths are $clog2 of the respective parameter (minimum 1 bit); counters never exceed parameter-1.
- Reset asserted mid-game returns to INICIAL immediately; the button must be released and pressed again before a new start_pulse.

Decomposition:
- Shared package (estados_pkg):
  - localparams EST_INICIAL=2'd0, EST_JOGO=2'd1, EST_VITORIA=2'd2, EST_DERROTA=2'd3.
  - The screen renderer and game logic use the same encoding.
- One sub-module: debounce_botao.
  - Contains the synchronizer, debounce counter and rising-edge pulse.
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, reset, entrada, pulso.
- The FSM, blink counter and end counter stay in controle_estados.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_FRAMES=2, END_SCREEN_FRAMES=3 for sim):
1. Reset released, 5 frame_ticks, no button -> estado=0; troca toggles after the 2nd and 4th tick (0->1->0).
2. botao_start bounces 1,0,1,0 on consecutive cycles, then held 1 for 10 cycles:
   - exactly one start_pulse, 7 cycles after the stable-high start;
   - next cycle estado=1 and reset_jogo=1 for 1 cycle; troca=0.
3. In JOGO, evento_vitoria and evento_derrota pulsed in the same cycle -> estado=3 next cycle. A later evento_vitoria leaves estado=3.
4. In VITORIA, 3 frame_ticks -> estado=0 the cycle after the 3rd tick. Repeat the test with a start_pulse on tick 1 -> estado=0 after that pulse.
5. reset=0 asserted asynchronously mid-cycle while estado=1 -> estado=0 and troca=0 without waiting for a clk edge. Button held through the release of reset -> no start_pulse until the button is released and pressed again.
